// File: rtl/dvs_aer_transmitter.sv
// DVS AER transmitter: streams (x, y, polarity) events onto a 10-bit AER bus as a Y word then an X word,
// each with a 4-phase req/ack handshake. Optional row-skip history is enabled by defining AER_TX_ROW_SKIP_EN.
module dvs_aer_transmitter #(
  parameter int X_BITS       = 9,
  parameter int Y_BITS       = 10,
  parameter int SETUP_CYCLES = 1,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_valid,
  input  logic [X_BITS-1:0] ev_x,
  input  logic [Y_BITS-1:0] ev_y,
  input  logic              ev_polarity,
  output logic              ev_ready,
  output logic [9:0]        aer,
  output logic              xsel,
  output logic              req,
  input  logic              ack,
  input  logic              err_clr,
  output logic              timeout_err,
  output logic [15:0]       tx_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_Y_SETUP = 3'd1;
  localparam logic [2:0] S_Y_REQ   = 3'd2;
  localparam logic [2:0] S_Y_REL   = 3'd3;
  localparam logic [2:0] S_X_SETUP = 3'd4;
  localparam logic [2:0] S_X_REQ   = 3'd5;
  localparam logic [2:0] S_X_REL   = 3'd6;

  localparam int SC_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETUP_LAST = SC_W'(SETUP_CYCLES - 1);
  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  logic [2:0]        state_reg;
  logic              ack_meta_reg;
  logic              ack_s_reg;
  logic [SC_W-1:0]   setup_cnt_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [X_BITS-1:0] x_reg;
  logic              pol_reg;
  logic [9:0]        aer_reg;
  logic              xsel_reg;
  logic              req_reg;
  logic              timeout_err_reg;
  logic [15:0]       tx_count_reg;

  logic [9:0] y_word;
  logic [9:0] x_word_in;
  logic [9:0] x_word_held;
  logic       timeout_hit;
  logic       timeout_fire;
  logic       y_done;
  logic       row_skip;

  assign y_word      = 10'(ev_y);
  assign x_word_in   = 10'({ev_x, ev_polarity});
  assign x_word_held = 10'({x_reg, pol_reg});
  assign timeout_hit = (ACK_TIMEOUT != 0) && (to_cnt_reg == TO_LAST);
  assign y_done      = (state_reg == S_Y_REL) && !ack_s_reg;

  always_comb begin
    timeout_fire = 1'b0;
    case (state_reg)
      S_Y_REQ, S_X_REQ: timeout_fire = timeout_hit && !ack_s_reg;
      S_Y_REL, S_X_REL: timeout_fire = timeout_hit && ack_s_reg;
      default:          timeout_fire = 1'b0;
    endcase
  end

  // ack is asynchronous to clk; only the synchronized copy steers the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta_reg <= 1'b0;
      ack_s_reg    <= 1'b0;
    end else begin
      ack_meta_reg <= ack;
      ack_s_reg    <= ack_meta_reg;
    end
  end

`ifdef AER_TX_ROW_SKIP_EN
  logic [Y_BITS-1:0] last_y_reg;
  logic              last_y_valid_reg;

  assign row_skip = last_y_valid_reg && (ev_y == last_y_reg);

  // history only counts rows whose Y word actually completed a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_y_reg       <= '0;
      last_y_valid_reg <= 1'b0;
    end else if (timeout_fire) begin
      last_y_valid_reg <= 1'b0;
    end else if (y_done) begin
      last_y_reg       <= aer_reg[Y_BITS-1:0];
      last_y_valid_reg <= 1'b1;
    end
  end
`else
  assign row_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      setup_cnt_reg   <= '0;
      to_cnt_reg      <= '0;
      x_reg           <= '0;
      pol_reg         <= 1'b0;
      aer_reg         <= '0;
      xsel_reg        <= 1'b0;
      req_reg         <= 1'b0;
      timeout_err_reg <= 1'b0;
      tx_count_reg    <= '0;
    end else begin
      if (timeout_fire) begin
        timeout_err_reg <= 1'b1;
      end else if (err_clr) begin
        timeout_err_reg <= 1'b0;
      end

      case (state_reg)
        S_IDLE: begin
          if (ev_valid) begin
            x_reg         <= ev_x;
            pol_reg       <= ev_polarity;
            setup_cnt_reg <= '0;
            if (row_skip) begin
              aer_reg   <= x_word_in;
              xsel_reg  <= 1'b1;
              state_reg <= S_X_SETUP;
            end else begin
              aer_reg   <= y_word;
              xsel_reg  <= 1'b0;
              state_reg <= S_Y_SETUP;
            end
          end
        end
        S_Y_SETUP, S_X_SETUP: begin
          // a stale ack from an aborted transfer must clear before the next request
          if (setup_cnt_reg == SETUP_LAST) begin
            if (!ack_s_reg) begin
              req_reg    <= 1'b1;
              to_cnt_reg <= '0;
              state_reg  <= (state_reg == S_Y_SETUP) ? S_Y_REQ : S_X_REQ;
            end
          end else begin
            setup_cnt_reg <= setup_cnt_reg + 1'b1;
          end
        end
        S_Y_REQ, S_X_REQ: begin
          if (ack_s_reg) begin
            req_reg    <= 1'b0;
            to_cnt_reg <= '0;
            state_reg  <= (state_reg == S_Y_REQ) ? S_Y_REL : S_X_REL;
          end else if (timeout_fire) begin
            req_reg   <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        S_Y_REL: begin
          if (!ack_s_reg) begin
            aer_reg       <= x_word_held;
            xsel_reg      <= 1'b1;
            setup_cnt_reg <= '0;
            state_reg     <= S_X_SETUP;
          end else if (timeout_fire) begin
            state_reg <= S_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        S_X_REL: begin
          if (!ack_s_reg) begin
            tx_count_reg <= tx_count_reg + 16'd1;
            state_reg    <= S_IDLE;
          end else if (timeout_fire) begin
            state_reg <= S_IDLE;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign ev_ready    = rst_n && (state_reg == S_IDLE);
  assign aer         = aer_reg;
  assign xsel        = xsel_reg;
  assign req         = req_reg;
  assign timeout_err = timeout_err_reg;
  assign tx_count    = tx_count_reg;

endmodule

// File: tb/tb_dvs_aer_transmitter.sv
// Self-checking bench for dvs_aer_transmitter: random events against a word-sequence reference model,
// plus directed timeout, stuck-ack and mid-transfer reset scenarios.
module tb_dvs_aer_transmitter;
  localparam int X_BITS       = 9;
  localparam int Y_BITS       = 10;
  localparam int SETUP_CYCLES = 2;
  localparam int ACK_TIMEOUT  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ev_valid = 1'b0;
  logic [X_BITS-1:0] ev_x = '0;
  logic [Y_BITS-1:0] ev_y = '0;
  logic              ev_polarity = 1'b0;
  logic              ev_ready;
  logic [9:0]        aer;
  logic              xsel;
  logic              req;
  logic              ack = 1'b0;
  logic              err_clr = 1'b0;
  logic              timeout_err;
  logic [15:0]       tx_count;

  always #5 clk = ~clk;

  dvs_aer_transmitter #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .SETUP_CYCLES(SETUP_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_x(ev_x), .ev_y(ev_y),
    .ev_polarity(ev_polarity), .ev_ready(ev_ready), .aer(aer), .xsel(xsel), .req(req),
    .ack(ack), .err_clr(err_clr), .timeout_err(timeout_err), .tx_count(tx_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model: queue of {xsel, aer} words expected on successive req rises
  logic [10:0]       exp_q[$];
  int                model_tx = 0;
  bit                hist_valid = 1'b0;
  logic [Y_BITS-1:0] hist_y = '0;

  int          rx_mode = 0;   // 0 responsive, 1 silent, 2 ack stuck high
  int          rx_wait = 0;
  logic        req_prev = 1'b0;
  logic [10:0] held_word = '0;
  logic [10:0] exp_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // receiver model answering req with a random delay
  always @(negedge clk) begin
    case (rx_mode)
      1: ack = 1'b0;
      2: ack = 1'b1;
      default: begin
        if (req != ack) begin
          if (rx_wait == 0) begin
            ack = req;
            rx_wait = $urandom_range(0, 4);
          end else begin
            rx_wait--;
          end
        end
      end
    endcase
  end

  // bus monitor: each request carries the next expected word, and the word holds while req is high
  always @(negedge clk) begin
    if (req && !req_prev) begin
      held_word = {xsel, aer};
      if (exp_q.size() == 0) begin
        chk("word_extra", 32'(held_word), 32'hFFFF);
      end else begin
        exp_word = exp_q.pop_front();
        chk("word", 32'(held_word), 32'(exp_word));
      end
    end else if (req && req_prev) begin
      chk("hold", 32'({xsel, aer}), 32'(held_word));
    end
    req_prev = req;
  end

  task automatic send_event(input logic [X_BITS-1:0] x, input logic [Y_BITS-1:0] y,
                            input logic pol, input bit chk_lat, input bit hold);
    logic [10:0] yw;
    logic [10:0] xw;
    bit          skip;
    int          n;
    @(negedge clk);
    ev_x = x; ev_y = y; ev_polarity = pol; ev_valid = 1'b1;
    n = 0;
    while (!ev_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(ev_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) ev_valid = 1'b0;
    yw = {1'b0, 10'(y)};
    xw = {1'b1, 10'({x, pol})};
    skip = 1'b0;
`ifdef AER_TX_ROW_SKIP_EN
    skip = hist_valid && (hist_y == y);
`endif
    if (rx_mode == 1) begin
      exp_q.push_back(skip ? xw : yw);
      hist_valid = 1'b0;
    end else begin
      if (!skip) exp_q.push_back(yw);
      exp_q.push_back(xw);
      hist_y = y;
      hist_valid = 1'b1;
      model_tx++;
    end
    $display("event x=%0d y=%0d pol=%0d skip=%0d", x, y, pol, skip);
    @(negedge clk);
    chk("load_word", 32'({xsel, aer}), 32'(skip ? xw : yw));
    chk("busy", 32'(ev_ready), 32'd0);
    if (chk_lat) begin
      for (int k = 0; k < SETUP_CYCLES; k++) begin
        chk("setup_req_low", 32'(req), 32'd0);
        @(negedge clk);
      end
      chk("req_rise", 32'(req), 32'd1);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(ev_ready && exp_q.size() == 0 && tx_count == 16'(model_tx)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(tx_count), 32'(model_tx & 32'hFFFF));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_ready"}, 32'(ev_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [Y_BITS-1:0] ry;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ev_ready), 32'd0);
    chk("rst_bus", 32'({req, xsel, aer}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(ev_ready), 32'd1);
    chk("rel_count", 32'(tx_count), 32'd0);
    chk("rel_err", 32'(timeout_err), 32'd0);

    send_event(9'd5, 10'd3, 1'b1, 1'b1, 1'b0);
    wait_done("single");

    send_event(9'd1, 10'd7, 1'b0, 1'b1, 1'b1);
    send_event(9'd2, 10'd7, 1'b1, 1'b1, 1'b1);
    send_event(9'd3, 10'd8, 1'b0, 1'b1, 1'b1);
    ev_valid = 1'b0;
    wait_done("rowseq");

    ry = 10'd100;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) != 0) ry = 10'($urandom_range(0, 1023));
      send_event(9'($urandom_range(0, 511)), ry, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    ev_valid = 1'b0;
    wait_done("random");

    rx_mode = 1;
    send_event(9'd10, 10'd500, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (req && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("to_req_len", 32'(n), 32'(ACK_TIMEOUT));
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_ready", 32'(ev_ready), 32'd1);
    chk("to_count", 32'(tx_count), 32'(model_tx));
    @(negedge clk);
    chk("to_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'd0);
    rx_mode = 0;

    rx_mode = 2;
    repeat (4) @(negedge clk);
    send_event(9'd77, 10'd500, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stuck_req", 32'(req), 32'd0);
    end
    rx_mode = 0;
    wait_done("stuck");

    send_event(9'd300, 10'd42, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(req && xsel) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_xreq", 32'({req, xsel}), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(req), 32'd0);
    chk("mid_rst_bus", 32'({xsel, aer}), 32'd0);
    chk("mid_rst_count", 32'(tx_count), 32'd0);
    chk("mid_rst_ready", 32'(ev_ready), 32'd0);
    exp_q.delete();
    model_tx = 0;
    hist_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_event(9'd301, 10'd42, 1'b0, 1'b1, 1'b0);
    wait_done("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dvs_aer_transmitter.md
# dvs_aer_transmitter

Transmit side of the DVS AER link: accepts preprocessed-format events (x, y, polarity) on a valid/ready stream and drives them onto the 10-bit AER bus with xsel/req, completing a 4-phase req/ack handshake per address word. Used as a DVS camera emulator for loopback and system tests against the AER receiver, and as the AER output port when events are forwarded to a downstream AER consumer.

## Interface
- X_BITS, 9, x address width; X word is {x, polarity}, so X_BITS+1 ≤ 10
- Y_BITS, 10, y address width; Y word is y zero-extended to 10 bits
- SETUP_CYCLES, 1, cycles aer/xsel are held stable before req rises (≥1)
- ACK_TIMEOUT, 1024, max cycles waiting for either ack edge; 0 disables timeout
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ev_valid  input  1  event available
- ev_x  input  X_BITS  event x address
- ev_y  input  Y_BITS  event y address
- ev_polarity  input  1  event polarity
- ev_ready  output  1  block can accept an event this cycle
- aer  output  10  AER address bus
- xsel  output  1  0 = Y word, 1 = X word
- req  output  1  AER request
- ack  input  1  AER acknowledge, asynchronous to clk
- err_clr  input  1  clears timeout_err
- timeout_err  output  1  sticky, set on any ack timeout
- tx_count  output  16  events fully transmitted, wraps 0xFFFF→0

## Operation
- ack passes a 2-flop synchronizer → ack_s; all decisions use ack_s only.
- States: IDLE, Y_SETUP, Y_REQ, Y_REL, X_SETUP, X_REQ, X_REL.
- IDLE: ev_ready=1. On ev_valid&ev_ready capture event, load aer={0,y}, xsel=0 → Y_SETUP.
- Y_SETUP: hold SETUP_CYCLES cycles and until ack_s=0 → Y_REQ with req=1.
- Y_REQ: wait ack_s=1 → req=0, Y_REL.
- Y_REL: wait ack_s=0 → load aer={0,x,polarity}, xsel=1 → X_SETUP.
- X_SETUP/X_REQ/X_REL: same as Y phase; on ack_s=0 in X_REL: tx_count+1, → IDLE.
- Timeout: counter resets on entry to *_REQ/*_REL; reaching ACK_TIMEOUT in either wait → req=0, timeout_err=1, event dropped (tx_count unchanged), → IDLE. Next event's SETUP still waits for ack_s=0.
- err_clr=1 clears timeout_err unless a timeout occurs the same cycle (set wins).
- aer/xsel change only while req=0 and in a SETUP load; held constant during REQ/REL.
- All outputs registered except ev_ready (decoded from state).

## Timing
- Reset values: aer=0, xsel=0, req=0, timeout_err=0, tx_count=0, state IDLE, ev_ready=1 after reset release (0 while rst_n=0).
- Accept at edge N → aer/xsel valid after N; req rises after edge N+SETUP_CYCLES (ack already low).
- ack rise at edge M → ack_s high after M+2 → req falls after M+3.
- One event per ≥ 2·(SETUP_CYCLES+~6) cycles; no pipelining, ev_ready low from accept to return to IDLE.
- Reset mid-handshake: req drops asynchronously, event lost, row-skip history invalidated.

## Configuration
- AER_TX_ROW_SKIP_EN defined: block keeps last transmitted y plus valid flag; if captured y equals last y and flag set, skip Y phase (IDLE → X_SETUP directly). Flag set on completing a Y phase, cleared on reset and on any timeout.
- Undefined: every event sends Y word then X word; no history register.

## Test plan
- Single event x=5, y=3, pol=1, receiver-model ack delay 4 cycles → aer=0x003 xsel=0, then aer=0x00B xsel=1, two full handshakes, tx_count=1, aer never changes while req=1.
- Back-to-back events (ev_valid held) → ev_ready low during transmit, second event starts after first X_REL, tx_count=2, no req overlap.
- ack never asserted, ACK_TIMEOUT=16 → req drops 16 cycles after rising, timeout_err=1, tx_count=0, ev_ready=1; err_clr → timeout_err=0.
- ack stuck high from reset → block stays in Y_SETUP with req=0; release ack → transfer proceeds normally.
- AER_TX_ROW_SKIP_EN: events (1,7),(2,7),(3,8) → Y words 7, 8 only; three X words; undefined → three Y words.
- rst_n asserted during X_REQ → req=0 immediately, all outputs at reset values, next event sends Y word even with row skip on.
